stack2seq4: RTL and testbench

Command sequencer for the 4-thread barrel data stack. It is the initiator side of the stack's `we`/`delta`/`wd`/`rd` port. It accepts push/pop/replace/peek commands tagged with a thread ID and holds each in a per-thread slot. It issues each command in the cycle where that thread's stack is in the live slot of the 4-phase rotation, tracks per-thread depth, rejects overflow and underflow, and returns the pre-operation top of stack. It sits between the debug/host command path and the pipelined stack.

---
 rtl/stack_pkg.sv | 37 +++
 rtl/stack2seq4_if.sv | 45 ++++
 rtl/stack_slot.sv | 52 +++++
 rtl/stack2seq4.sv | 105 ++++++++++
 tb/tb_stack2seq4.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared constants for the 4-thread barrel stack and its command sequencer:
// command op codes, stack move codes, and the op-to-port encoding.
package stack_pkg;

    localparam int WIDTH    = 16;
    localparam int NTHREADS = 4;

    typedef logic [1:0] op_t;

    localparam op_t OP_PEEK = 2'd0;
    localparam op_t OP_PUSH = 2'd1;
    localparam op_t OP_POP  = 2'd2;
    localparam op_t OP_REPL = 2'd3;

    localparam logic [1:0] D_HOLD = 2'b00;
    localparam logic [1:0] D_PUSH = 2'b01;
    localparam logic [1:0] D_POP  = 2'b11;

    typedef struct packed {
        logic       we;
        logic [1:0] delta;
    } stk_ctl_t;

    function automatic stk_ctl_t op_ctl(input op_t op);
        stk_ctl_t c;
        c.we    = 1'b0;
        c.delta = D_HOLD;
        case (op)
            OP_PUSH: begin c.we = 1'b1; c.delta = D_PUSH; end
            OP_POP:  begin c.we = 1'b0; c.delta = D_POP;  end
            OP_REPL: begin c.we = 1'b1; c.delta = D_HOLD; end
            default: begin c.we = 1'b0; c.delta = D_HOLD; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stack2seq4_if.sv
// Command, stack-port and response bundle of the sequencer; master is the
// host/stack environment, slave is the sequencer itself.
interface stack2seq4_if #(
    parameter int DEPTH = 18,
    parameter int WIDTH = 16
);
    localparam int DW = $clog2(DEPTH + 2);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_thread;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    logic             stk_we;
    logic [1:0]       stk_delta;
    logic [WIDTH-1:0] stk_wd;
    logic [WIDTH-1:0] stk_rd;
    logic [1:0]       phase;

    logic             rsp_valid;
    logic [1:0]       rsp_thread;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    logic [DW-1:0]    depth0;
    logic [DW-1:0]    depth1;
    logic [DW-1:0]    depth2;
    logic [DW-1:0]    depth3;

    modport master (
        output cmd_valid, cmd_thread, cmd_op, cmd_data, stk_rd,
        input  cmd_ready, stk_we, stk_delta, stk_wd, phase,
        input  rsp_valid, rsp_thread, rsp_data, rsp_err,
        input  depth0, depth1, depth2, depth3
    );

    modport slave (
        input  cmd_valid, cmd_thread, cmd_op, cmd_data, stk_rd,
        output cmd_ready, stk_we, stk_delta, stk_wd, phase,
        output rsp_valid, rsp_thread, rsp_data, rsp_err,
        output depth0, depth1, depth2, depth3
    );

endinterface

// File: rtl/stack_slot.sv
// One thread's single-entry command slot, depth counter and legality check.
// Issues in the cycle its thread is live; a load in that same cycle refills it.
module stack_slot #(
    parameter int DEPTH = 18,
    parameter int WIDTH = 16,
    parameter int DW    = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [1:0]       load_op,
    input  logic [WIDTH-1:0] load_data,
    input  logic             live,
    output logic             full,
    output logic             issuing,
    output logic             legal,
    output logic [1:0]       op,
    output logic [WIDTH-1:0] data,
    output logic [DW-1:0]    depth
);
    import stack_pkg::*;

    localparam logic [DW-1:0] CAP = DW'(DEPTH + 1);

    assign issuing = full && live;
    assign legal   = (op == OP_PUSH) ? (depth != CAP) : (depth != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            op    <= OP_PEEK;
            data  <= '0;
            depth <= '0;
        end else begin
            if (load) begin
                full <= 1'b1;
                op   <= load_op;
                data <= load_data;
            end else if (issuing) begin
                full <= 1'b0;
            end
            // Rejected commands leave the count alone.
            if (issuing && legal) begin
                if (op == OP_PUSH)
                    depth <= depth + 1'b1;
                else if (op == OP_POP)
                    depth <= depth - 1'b1;
            end
        end
    end

endmodule

// File: rtl/stack2seq4.sv
// Sequencer for the 4-thread barrel stack: issue 1-4 cycles after accept, response one cycle later.
// Per-thread slot backpressures via cmd_ready; responses have no backpressure.
module stack2seq4 #(
    parameter int DEPTH = 18,
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    stack2seq4_if.slave  bus
);
    import stack_pkg::*;

    localparam int DW = $clog2(DEPTH + 2);

    logic [1:0]          phase_q;
    logic [NTHREADS-1:0] full;
    logic [NTHREADS-1:0] issuing;
    logic [NTHREADS-1:0] legal;
    logic [NTHREADS-1:0] load;
    logic [1:0]          slot_op   [NTHREADS];
    logic [WIDTH-1:0]    slot_data [NTHREADS];
    logic [DW-1:0]       depth     [NTHREADS];

    logic                ready;
    logic                accept;
    logic                iss;
    logic                iss_legal;
    stk_ctl_t            ctl;

    for (genvar k = 0; k < NTHREADS; k++) begin : g_slot
        stack_slot #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH),
            .DW    (DW)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .load_op   (bus.cmd_op),
            .load_data (bus.cmd_data),
            .live      ((phase_q == 2'(k)) && !reset),
            .full      (full[k]),
            .issuing   (issuing[k]),
            .legal     (legal[k]),
            .op        (slot_op[k]),
            .data      (slot_data[k]),
            .depth     (depth[k])
        );
    end

    // A slot that is emptying this cycle can take the next command at once.
    assign ready         = !reset && (!full[bus.cmd_thread] || issuing[bus.cmd_thread]);
    assign accept        = bus.cmd_valid && ready;
    assign bus.cmd_ready = ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < NTHREADS; k++)
            load[k] = accept && (bus.cmd_thread == 2'(k));
    end

    assign iss       = issuing[phase_q];
    assign iss_legal = legal[phase_q];
    assign ctl       = op_ctl(slot_op[phase_q]);

    always_comb begin
        bus.stk_we    = 1'b0;
        bus.stk_delta = D_HOLD;
        bus.stk_wd    = slot_data[phase_q];
        if (iss && iss_legal) begin
            bus.stk_we    = ctl.we;
            bus.stk_delta = ctl.delta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            phase_q <= 2'd0;
        else
            phase_q <= phase_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_thread <= 2'd0;
            bus.rsp_data   <= '0;
        end else begin
            bus.rsp_valid <= iss;
            bus.rsp_err   <= iss && !iss_legal;
            if (iss) begin
                bus.rsp_thread <= phase_q;
                bus.rsp_data   <= bus.stk_rd;
            end
        end
    end

    assign bus.phase  = phase_q;
    assign bus.depth0 = depth[0];
    assign bus.depth1 = depth[1];
    assign bus.depth2 = depth[2];
    assign bus.depth3 = depth[3];

endmodule

// File: tb/tb_stack2seq4.sv
// Directed bench for stack2seq4 with a behavioural barrel stack and a response scoreboard.
module tb_stack2seq4;
    import stack_pkg::*;

    localparam int DEPTH = 18;
    localparam int W     = 16;
    localparam int CAP   = DEPTH + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack2seq4_if #(.DEPTH(DEPTH), .WIDTH(W)) bus();

    stack2seq4 #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         thread;
        logic       err;
        logic       chk_data;
        logic [W-1:0] data;
        logic       we;
        logic [1:0] delta;
        logic [W-1:0] wd;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [1:0] ph_m = 2'd0;
    bit started = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        ph_m <= reset ? 2'd0 : ph_m + 2'd1;
    end

    // Behavioural attached stack: top of the live thread is presented on stk_rd.
    logic [W-1:0] mem [4][CAP+1];
    int           sp  [4];

    always_comb begin
        bus.stk_rd = '0;
        if (bus.phase !== 2'bxx && sp[bus.phase] > 0)
            bus.stk_rd = mem[bus.phase][sp[bus.phase]-1];
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) sp[k] <= 0;
        end else if (bus.phase !== 2'bxx) begin
            if (bus.stk_delta == D_PUSH && sp[bus.phase] <= CAP) begin
                mem[bus.phase][sp[bus.phase]] <= bus.stk_wd;
                sp[bus.phase] <= sp[bus.phase] + 1;
            end else if (bus.stk_delta == D_POP && sp[bus.phase] > 0) begin
                sp[bus.phase] <= sp[bus.phase] - 1;
            end else if (bus.stk_delta == D_HOLD && bus.stk_we && sp[bus.phase] > 0) begin
                mem[bus.phase][sp[bus.phase]-1] <= bus.stk_wd;
            end
        end
    end

    // Reference LIFO per thread, updated in accept order.
    int           ref_d [4];
    logic [W-1:0] ref_s [4][CAP];

    task automatic record(input int t, input logic [1:0] op, input logic [W-1:0] d);
        exp_t x;
        x.thread   = t;
        x.chk_data = (ref_d[t] > 0);
        x.data     = (ref_d[t] > 0) ? ref_s[t][ref_d[t]-1] : '0;
        x.err      = (op == OP_PUSH) ? (ref_d[t] == CAP) : (ref_d[t] == 0);
        x.we       = 1'b0;
        x.delta    = D_HOLD;
        x.wd       = d;
        x.acc_cyc  = cyc;
        if (!x.err) begin
            case (op)
                OP_PUSH: begin x.we = 1'b1; x.delta = D_PUSH; ref_s[t][ref_d[t]] = d; ref_d[t]++; end
                OP_POP:  begin x.delta = D_POP; ref_d[t]--; end
                OP_REPL: begin x.we = 1'b1; ref_s[t][ref_d[t]-1] = d; end
                default: ;
            endcase
        end
        sb.push_back(x);
    endtask

    task automatic send(input int t, input logic [1:0] op, input logic [W-1:0] d);
        bit done = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_thread = 2'(t);
        bus.cmd_op     = op;
        bus.cmd_data   = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                record(t, op, d);
                done = 1;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        chk("send_accept", done, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    logic         last_we;
    logic [1:0]   last_delta;
    logic [1:0]   last_phase;
    logic [W-1:0] last_wd;
    int run = 0;
    int max_run = 0;

    always @(negedge clk) begin
        int idx;
        idx = -1;
        if (started && !reset) chk("phase", bus.phase, ph_m);
        if (bus.rsp_valid === 1'b1) begin
            for (int i = 0; i < sb.size(); i++)
                if (idx < 0 && sb[i].thread == int'(bus.rsp_thread)) idx = i;
            chk("rsp_matched", idx >= 0, 1);
            if (idx >= 0) begin
                e = sb[idx];
                sb.delete(idx);
                chk("rsp_err", bus.rsp_err, e.err);
                if (e.chk_data) chk("rsp_data", bus.rsp_data, e.data);
                chk("issue_phase", last_phase, e.thread);
                chk("issue_we", last_we, e.we);
                chk("issue_delta", last_delta, e.delta);
                if (e.we) chk("issue_wd", last_wd, e.wd);
                chk("latency", (cyc - e.acc_cyc >= 2) && (cyc - e.acc_cyc <= 5), 1);
            end
            run++;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
        last_we    = bus.stk_we;
        last_delta = bus.stk_delta;
        last_phase = bus.phase;
        last_wd    = bus.stk_wd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        for (int k = 0; k < 4; k++) ref_d[k] = 0;
        reset          = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_thread = 2'd2;
        bus.cmd_op     = OP_PUSH;
        bus.cmd_data   = 16'hDEAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", bus.cmd_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        started = 1;

        // Reset state
        @(negedge clk);
        chk("rst_phase", bus.phase, 0);
        chk("rst_depth0", bus.depth0, 0);
        chk("rst_depth1", bus.depth1, 0);
        chk("rst_depth2", bus.depth2, 0);
        chk("rst_depth3", bus.depth3, 0);
        chk("rst_we", bus.stk_we, 0);
        chk("rst_delta", bus.stk_delta, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_thread", bus.rsp_thread, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        for (int t = 0; t < 4; t++) begin
            bus.cmd_thread = 2'(t);
            #1;
            chk("rst_ready", bus.cmd_ready, 1);
        end
        @(posedge clk); #1;

        // Push then peek, then replace and peek again
        send(2, OP_PUSH, 16'h1234);
        send(2, OP_PEEK, 16'h0000);
        send(2, OP_REPL, 16'h5678);
        send(2, OP_PEEK, 16'h0000);
        drain();
        chk("depth2_after_push", bus.depth2, 1);
        send(2, OP_POP, 16'h0000);
        drain();

        // Thread isolation
        for (int k = 0; k < 4; k++) send(k, OP_PUSH, 16'(16'hA0 + k));
        drain();
        max_run = 0;
        for (int k = 0; k < 4; k++) send(k, OP_POP, 16'h0000);
        drain();
        chk("pop_consecutive", max_run, 4);
        chk("iso_depth0", bus.depth0, 0);
        chk("iso_depth1", bus.depth1, 0);
        chk("iso_depth2", bus.depth2, 0);
        chk("iso_depth3", bus.depth3, 0);

        // Underflow
        send(1, OP_POP, 16'h0000);
        send(3, OP_PEEK, 16'h0000);
        drain();
        chk("underflow_depth1", bus.depth1, 0);

        // Overflow and LIFO order
        for (int i = 0; i < CAP; i++) send(0, OP_PUSH, 16'(16'h100 + i));
        send(0, OP_PUSH, 16'hBAD0);
        drain();
        chk("overflow_depth0", bus.depth0, CAP);
        for (int i = 0; i < CAP; i++) send(0, OP_POP, 16'h0000);
        drain();
        chk("drained_depth0", bus.depth0, 0);

        // Backpressure: thread 3 offered every cycle
        nacc = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_thread = 2'd3;
        bus.cmd_op     = OP_PUSH;
        bus.cmd_data   = 16'h300;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i > 0) chk("bp_ready", bus.cmd_ready, ph_m == 2'd3);
            if (bus.cmd_ready === 1'b1) begin
                record(3, OP_PUSH, bus.cmd_data);
                if (i > 0) nacc++;
            end
            @(posedge clk); #1;
            bus.cmd_data = bus.cmd_data + 16'd1;
        end
        bus.cmd_valid = 1'b0;
        chk("bp_rate", nacc, 4);
        drain();
        for (int i = 0; i < 5; i++) send(3, OP_POP, 16'h0000);
        drain();

        // Reset with all four slots full
        for (int i = 0; i < 8 && ph_m != 2'd3; i++) @(negedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) send(k, OP_PUSH, 16'(16'hC0 + k));
        reset = 1'b1;
        sb.delete();
        for (int k = 0; k < 4; k++) ref_d[k] = 0;
        @(negedge clk);
        chk("mid_rst_we", bus.stk_we, 0);
        chk("mid_rst_delta", bus.stk_delta, 0);
        chk("mid_rst_ready", bus.cmd_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_phase", bus.phase, 0);
        chk("post_rst_rsp_valid", bus.rsp_valid, 0);
        chk("post_rst_depth0", bus.depth0, 0);
        chk("post_rst_depth1", bus.depth1, 0);
        chk("post_rst_depth2", bus.depth2, 0);
        chk("post_rst_depth3", bus.depth3, 0);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        send(0, OP_PUSH, 16'h00D0);
        send(0, OP_POP, 16'h0000);
        drain();
        chk("final_depth0", bus.depth0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
